bank_score_writer: RTL and testbench
====================================

BANK_SCORE_WRITER -- requirements
Module: bank_score_writer

Interface
REQ-001 Parameter DEPTH, default 256, SHALL be the score-memory entries available for writing.
REQ-002 Parameter ADDR_W, default 8, SHALL be the write-address width, with 2**ADDR_W >= DEPTH.
REQ-003 Parameter DATA_W, default 32, SHALL be the width of one score word.
REQ-004 Port clk, input, 1: SHALL be the single clock, with all state on its rising edge.
REQ-005 Port rst_n, input, 1: SHALL be an asynchronous, active-low reset.
REQ-006 Port in_data, input, 8: SHALL carry one ASCII byte of puzzle input.
REQ-007 Port in_valid, input, 1: SHALL mark in_data valid.
REQ-008 Port in_last, input, 1: SHALL mark the final byte of the input stream, qualified by in_valid.
REQ-009 Port in_ready, output, 1: SHALL mark that the block accepts a byte this cycle.
REQ-010 Port wr_en, output, 1: SHALL be the one-cycle write strobe to the score memory.
REQ-011 Port wr_addr, output, ADDR_W: SHALL be the score-memory write address.
REQ-012 Port wr_data, output, DATA_W: SHALL be the line score, zero-extended.
REQ-013 Port line_count, output, ADDR_W+1: SHALL be the number of scores written.
REQ-014 Port done, output, 1: SHALL be a sticky end-of-stream flag.
REQ-015 Port full, output, 1: SHALL be a sticky flag meaning DEPTH scores have been written.
REQ-016 Port bad_char, output, 1: SHALL be a sticky flag meaning an illegal byte was seen.

Function
REQ-017 A byte SHALL be accepted only on a cycle where in_valid && in_ready.
REQ-018 in_ready SHALL equal state==RUN, driven combinationally from state.
REQ-019 The FSM SHALL have exactly three states: RUN, FULL and DONE.
REQ-020 The FSM SHALL go RUN->FULL when a write makes line_count==DEPTH.
REQ-021 The FSM SHALL go RUN->DONE when an in_last byte is accepted.
REQ-022 FULL and DONE SHALL be terminal until reset.
REQ-023 If both RUN exits occur in the same cycle, FULL SHALL take priority.
REQ-024 In FULL, done SHALL stay 0.
REQ-025 Per line, the block SHALL track max_prev (4b), best (7b), has_digit and has_pair.
REQ-026 On an accepted digit d (0x30-0x39) with has_digit=1: best<=max(best,10*max_prev+d) and has_pair<=1.
REQ-027 On every accepted digit, max_prev<=max(max_prev,d) and has_digit<=1.
REQ-028 An accepted 0x0A SHALL end the line.
REQ-029 An accepted 0x0D SHALL be ignored without error.
REQ-030 Any other accepted byte SHALL set bad_char and be otherwise ignored.
REQ-031 At line end with has_digit=1, the block SHALL write best if has_pair, else 0.
REQ-032 After that write, all per-line state SHALL clear.
REQ-033 A line with no digits (empty line) SHALL produce no write.
REQ-034 An accepted in_last byte SHALL first be processed as a normal byte.
REQ-035 If that in_last byte leaves an unterminated line holding digits, that line SHALL be written as if newline-terminated.
REQ-036 A write SHALL appear one cycle after the terminating byte is accepted: wr_en=1 for one cycle, wr_addr=line_count (pre-increment), wr_data=score.
REQ-037 line_count SHALL increment in the same cycle as wr_en.
REQ-038 wr_en, wr_addr and wr_data SHALL be registered outputs.
REQ-039 At most one write SHALL occur per accepted byte.
REQ-040 Back-to-back newlines ending non-empty lines SHALL give writes on consecutive cycles.
REQ-041 A write that makes line_count==DEPTH SHALL assert full on the same cycle as that write.
REQ-042 Once full is asserted, in_ready SHALL be 0 from the following cycle.
REQ-043 No write SHALL ever occur with wr_addr >= DEPTH.

Reset
REQ-044 rst_n low SHALL immediately clear all state, counters and flags, and set the FSM to RUN.
REQ-045 During reset, outputs SHALL be in_ready=0, wr_en=0, wr_addr=0, wr_data=0, line_count=0, done=0, full=0, bad_char=0.
REQ-046 in_ready SHALL rise no earlier than the first clock edge after rst_n deasserts.
REQ-047 Reset mid-line SHALL discard the partial line, and any write pending on that edge SHALL be suppressed.

Structure
REQ-048 Package bank_pkg SHALL hold the DEPTH/ADDR_W/DATA_W defaults, ASCII constants ('0', '9', LF, CR) and the FSM state enum.
REQ-049 Per-line digit tracking (REQ-025 to REQ-027, REQ-031 to REQ-032) SHALL live in sub-module bank_line_max, with inputs digit, digit_valid and clear, and outputs score[6:0] and has_digit.
REQ-050 bank_score_writer SHALL own only the FSM, the handshake and the write port.

Verification
REQ-051 Stream "987654321111111\n811111111111119\n234234234234278\n818181911112111\n" with in_last on the final LF -> writes 98, 89, 78, 92 at addresses 0-3; line_count=4; done=1; scores sum to 357.
REQ-052 Stream "5\r\n\n12" with in_last on '2' -> writes 0 at addr 0 and 12 at addr 1; no write for the empty line; bad_char=0.
REQ-053 With DEPTH=4, send 6 lines "11\n" -> exactly 4 writes of 11; full=1 on the 4th write cycle; in_ready=0 afterwards; done=0.
REQ-054 Stream "9x1\n" -> a single write of 91; bad_char=1.
REQ-055 Hold in_valid high continuously while toggling in_ready via FULL, and separately assert rst_n low mid-line -> no byte lost or duplicated; all outputs return to reset values; the next line writes at addr 0.

Source files
------------

// File: rtl/bank_pkg.sv
// Shared defaults, ASCII constants and FSM encoding
// for the bank score writer.
package bank_pkg;

  localparam int DEPTH_DEF  = 256;
  localparam int ADDR_W_DEF = 8;
  localparam int DATA_W_DEF = 32;

  localparam logic [7:0] CH_0  = 8'h30;
  localparam logic [7:0] CH_9  = 8'h39;
  localparam logic [7:0] CH_LF = 8'h0a;
  localparam logic [7:0] CH_CR = 8'h0d;

  typedef enum logic [1:0] {
    RUN  = 2'd0,
    FULL = 2'd1,
    DONE = 2'd2
  } state_t;

  function automatic logic is_digit(input logic [7:0] b);
    return (b >= CH_0) && (b <= CH_9);
  endfunction

endpackage

// File: rtl/bank_line_max.sv
// Per-line best two-digit tracker; outputs reflect the line
// including the digit presented this cycle.
module bank_line_max
  import bank_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] digit,
  input  logic       digit_valid,
  input  logic       clear,
  output logic [6:0] score,
  output logic       has_digit
);

  logic [3:0] max_prev, max_nxt;
  logic [6:0] best, best_nxt, cand;
  logic       seen, seen_nxt;
  logic       pair, pair_nxt;

  always_comb begin
    cand     = 7'(max_prev) * 7'd10 + 7'(digit);
    best_nxt = best;
    pair_nxt = pair;
    max_nxt  = max_prev;
    seen_nxt = seen;
    if (digit_valid) begin
      if (seen) begin
        pair_nxt = 1'b1;
        if (cand > best) best_nxt = cand;
      end
      if (digit > max_prev) max_nxt = digit;
      seen_nxt = 1'b1;
    end
    score     = pair_nxt ? best_nxt : 7'd0;
    has_digit = seen_nxt;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      max_prev <= '0;
      best     <= '0;
      seen     <= 1'b0;
      pair     <= 1'b0;
    end else if (clear) begin
      max_prev <= '0;
      best     <= '0;
      seen     <= 1'b0;
      pair     <= 1'b0;
    end else begin
      max_prev <= max_nxt;
      best     <= best_nxt;
      seen     <= seen_nxt;
      pair     <= pair_nxt;
    end
  end

endmodule

// File: rtl/bank_score_writer.sv
// Byte-stream handshake, RUN/FULL/DONE control and
// registered score-memory write port.
module bank_score_writer
  import bank_pkg::*;
#(
  parameter int DEPTH  = DEPTH_DEF,
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [7:0]        in_data,
  input  logic              in_valid,
  input  logic              in_last,
  output logic              in_ready,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [DATA_W-1:0] wr_data,
  output logic [ADDR_W:0]   line_count,
  output logic              done,
  output logic              full,
  output logic              bad_char
);

  localparam logic [ADDR_W:0] LAST_IDX = (ADDR_W+1)'(DEPTH - 1);
  localparam logic [ADDR_W:0] ONE      = (ADDR_W+1)'(1);

  state_t     state, state_nxt;
  logic       active;
  logic       acc, is_dig, is_lf, is_cr, is_bad;
  logic       eol, wr_go, last_wr;
  logic [6:0] score;
  logic       has_digit;

  // active holds in_ready low until the first edge out of reset
  assign in_ready = active && (state == RUN);
  assign done     = (state == DONE);
  assign full     = (state == FULL);

  always_comb begin
    acc     = in_valid && in_ready;
    is_dig  = is_digit(in_data);
    is_lf   = (in_data == CH_LF);
    is_cr   = (in_data == CH_CR);
    is_bad  = !(is_dig || is_lf || is_cr);
    eol     = acc && (is_lf || in_last);
    wr_go   = eol && has_digit;
    last_wr = wr_go && (line_count == LAST_IDX);
    state_nxt = state;
    if (last_wr)
      state_nxt = FULL;
    else if (acc && in_last)
      state_nxt = DONE;
  end

  bank_line_max u_line (
    .clk        (clk),
    .rst_n      (rst_n),
    .digit      (in_data[3:0]),
    .digit_valid(acc && is_dig),
    .clear      (eol),
    .score      (score),
    .has_digit  (has_digit)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= RUN;
      active     <= 1'b0;
      wr_en      <= 1'b0;
      wr_addr    <= '0;
      wr_data    <= '0;
      line_count <= '0;
      bad_char   <= 1'b0;
    end else begin
      state  <= state_nxt;
      active <= 1'b1;
      wr_en  <= wr_go;
      if (wr_go) begin
        wr_addr    <= line_count[ADDR_W-1:0];
        wr_data    <= DATA_W'(score);
        line_count <= line_count + ONE;
      end
      if (acc && is_bad) bad_char <= 1'b1;
    end
  end

endmodule

// File: tb/tb_bank_score_writer.sv
// Scoreboard bench: reference line scores from a brute-force
// pair search, monitor compares each registered write.
module tb_bank_score_writer;
  import bank_pkg::*;

  localparam int DEPTH = 6;
  localparam int AW    = 3;
  localparam int DW    = 32;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [7:0]    in_data = 8'h00;
  logic          in_valid = 1'b0;
  logic          in_last = 1'b0;
  logic          in_ready;
  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic [DW-1:0] wr_data;
  logic [AW:0]   line_count;
  logic          done, full, bad_char;

  bank_score_writer #(.DEPTH(DEPTH), .ADDR_W(AW), .DATA_W(DW)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_data(in_data), .in_valid(in_valid), .in_last(in_last),
    .in_ready(in_ready),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .line_count(line_count),
    .done(done), .full(full), .bad_char(bad_char)
  );

  always #5 clk = ~clk;

  typedef struct {
    int addr;
    int data;
    bit last;
  } exp_t;

  int         n_chk = 0;
  int         n_pass = 0;
  exp_t       sb[$];
  logic [7:0] stream[$];
  int         scores[$];
  int         digs[$];
  bit         exp_bad;
  int         wr_sum = 0;

  task automatic chk(string name, longint act, longint exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (rst_n && wr_en) begin
      if (sb.size() == 0) begin
        chk("unexpected_write", 1, 0);
      end else begin
        e = sb.pop_front();
        chk("wr_addr", wr_addr, e.addr);
        chk("wr_data", wr_data, e.data);
        chk("full_with_write", full, e.last);
        wr_sum += int'(wr_data);
      end
    end
  end

  task automatic flush();
    int best;
    if (digs.size() > 0) begin
      best = 0;
      for (int i = 0; i < digs.size(); i++)
        for (int j = i + 1; j < digs.size(); j++)
          if (10 * digs[i] + digs[j] > best)
            best = 10 * digs[i] + digs[j];
      scores.push_back(best);
      digs.delete();
    end
  endtask

  task automatic model();
    scores.delete();
    digs.delete();
    exp_bad = 1'b0;
    for (int i = 0; i < stream.size(); i++) begin
      if (stream[i] >= 8'h30 && stream[i] <= 8'h39)
        digs.push_back(int'(stream[i]) - 48);
      else if (stream[i] == 8'h0a)
        flush();
      else if (stream[i] != 8'h0d)
        exp_bad = 1'b1;
    end
    flush();
  endtask

  task automatic load(string s);
    stream.delete();
    for (int i = 0; i < s.len(); i++) stream.push_back(s[i]);
  endtask

  task automatic do_reset();
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    in_valid = 1'b0;
    in_last = 1'b0;
    #1;
    chk("rst_in_ready", in_ready, 0);
    chk("rst_wr_en", wr_en, 0);
    chk("rst_wr_addr", wr_addr, 0);
    chk("rst_wr_data", wr_data, 0);
    chk("rst_line_count", line_count, 0);
    chk("rst_done", done, 0);
    chk("rst_full", full, 0);
    chk("rst_bad_char", bad_char, 0);
    sb.delete();
    wr_sum = 0;
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("ready_at_release", in_ready, 0);
    @(negedge clk);
    chk("ready_after_edge", in_ready, 1);
  endtask

  task automatic send_stream(bit gaps);
    int  n, nw, w;
    bit  stopped;
    model();
    n  = scores.size();
    nw = (n < DEPTH) ? n : DEPTH;
    for (int k = 0; k < nw; k++)
      sb.push_back('{k, scores[k], (k == DEPTH - 1)});
    stopped = 1'b0;
    for (int i = 0; i < stream.size() && !stopped; i++) begin
      if (gaps && $urandom_range(0, 3) == 0) begin
        in_valid = 1'b0;
        @(negedge clk);
      end
      in_valid = 1'b1;
      in_data  = stream[i];
      in_last  = (i == stream.size() - 1);
      w = 0;
      while (!in_ready && w < 20) begin
        @(negedge clk);
        w++;
      end
      if (!in_ready) begin
        stopped = 1'b1;
        if (n < DEPTH) chk("ready_timeout", 0, 1);
      end else begin
        @(negedge clk);
      end
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
    repeat (3) @(negedge clk);
    if (n >= DEPTH) chk("stalled_after_full", stopped, 1);
    chk("sb_drained", sb.size(), 0);
    chk("line_count", line_count, nw);
    chk("done", done, (n < DEPTH));
    chk("full", full, (n >= DEPTH));
    chk("bad_char", bad_char, exp_bad);
    chk("ready_end", in_ready, 0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    string s;
    int    nl, len, r;
    logic [7:0] bads [4];
    bads[0] = 8'h20;
    bads[1] = 8'h2f;
    bads[2] = 8'h3a;
    bads[3] = 8'h41;

    do_reset();
    load("987654321111111\n811111111111119\n234234234234278\n818181911112111\n");
    send_stream(1'b0);
    chk("score_sum", wr_sum, 357);

    do_reset();
    load("5\r\n\n12");
    send_stream(1'b1);

    do_reset();
    load("9x1\n");
    send_stream(1'b0);

    do_reset();
    load("11\n11\n11\n11\n11\n11\n11\n11\n");
    send_stream(1'b0);

    do_reset();
    in_valid = 1'b1;
    in_data  = 8'h39;
    repeat (2) @(negedge clk);
    in_data = 8'h38;
    do_reset();
    load("12\n");
    send_stream(1'b0);

    for (int t = 0; t < 12; t++) begin
      do_reset();
      stream.delete();
      nl = $urandom_range(1, 5);
      for (int l = 0; l < nl; l++) begin
        len = $urandom_range(0, 8);
        for (int c = 0; c < len; c++) begin
          r = $urandom_range(0, 19);
          if (r == 0) stream.push_back(8'h0d);
          else if (r == 1) stream.push_back(bads[$urandom_range(0, 3)]);
          else stream.push_back(8'(8'h30 + $urandom_range(0, 9)));
        end
        if (l < nl - 1 || $urandom_range(0, 1) == 1)
          stream.push_back(8'h0a);
      end
      if (stream.size() == 0) stream.push_back(8'h37);
      send_stream(1'b1);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
